// File: rtl/param_delta_sequencer.sv
// param_delta_sequencer: per-pixel microphone delay indices from a programmable
// squared-radius threshold table, one mic per cycle through a 3-stage pipeline.
module param_delta_sequencer #(
    parameter int MIC_ROWS   = 4,
    parameter int MIC_COLS   = 4,
    parameter int MIC_PITCH  = 80,
    parameter int COORD_W    = 10,
    parameter int N_THR      = 32,
    parameter int DELTA_W    = 8,
    parameter int DELTA_BASE = 147,
    parameter int R2_W       = 2*(COORD_W+1)+1
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic signed [COORD_W-1:0]          i_p_x,
    input  logic signed [COORD_W-1:0]          i_p_y,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [MIC_ROWS*MIC_COLS*DELTA_W-1:0] o_delta,
    input  logic                               i_thr_we,
    input  logic [$clog2(N_THR)-1:0]           i_thr_addr,
    input  logic [R2_W-1:0]                    i_thr_data
);
    localparam int N_MIC  = MIC_ROWS*MIC_COLS;
    localparam int MW     = N_MIC > 1 ? $clog2(N_MIC) : 1;
    localparam int IW     = $clog2(N_MIC+1);
    localparam int RW     = COORD_W+1;
    localparam int HALF_X = (MIC_COLS-1)*MIC_PITCH/2;
    localparam int HALF_Y = (MIC_ROWS-1)*MIC_PITCH/2;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                   state;
    logic signed [COORD_W-1:0] px, py;
    logic [IW-1:0]            iss;
    logic                     v0, v1, v2, issue;
    logic [MW-1:0]            m0, m1, m2;
    logic signed [RW-1:0]     rx, ry, rx_n, ry_n;
    logic signed [2*RW-1:0]   ex, ey;
    logic [R2_W-1:0]          r2, r2_n;
    logic [R2_W-1:0]          thr [N_THR];
    logic [DELTA_W-1:0]       delta_n;
    int                       cnt;

    always_comb begin
        issue = state == COMPUTE && int'(iss) < N_MIC;
        rx_n = RW'(px) + RW'(HALF_X - (int'(iss) % MIC_COLS) * MIC_PITCH);
        ry_n = RW'(py) + RW'(HALF_Y - (int'(iss) / MIC_COLS) * MIC_PITCH);
        ex = (2*RW)'(rx);
        ey = (2*RW)'(ry);
        r2_n = {1'b0, ex*ex} + {1'b0, ey*ey};
        cnt = 0;
        for (int k = 0; k < N_THR; k++) cnt = cnt + (r2 > thr[k] ? 1 : 0);
        delta_n = DELTA_W'(DELTA_BASE + cnt);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_delta <= '0;
            px      <= '0;
            py      <= '0;
            iss     <= '0;
            v0      <= 1'b0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            m0      <= '0;
            m1      <= '0;
            m2      <= '0;
            rx      <= '0;
            ry      <= '0;
            r2      <= '0;
            for (int k = 0; k < N_THR; k++) thr[k] <= '1;
        end else begin
            // table is frozen outside IDLE so an in-flight pixel sees one consistent table
            if (state == IDLE && i_thr_we && int'(i_thr_addr) < N_THR) thr[i_thr_addr] <= i_thr_data;
            v0 <= issue;
            v1 <= v0;
            v2 <= v1;
            if (issue) begin
                rx  <= rx_n;
                ry  <= ry_n;
                m0  <= MW'(iss);
                iss <= iss + 1'b1;
            end
            if (v0) begin
                r2 <= r2_n;
                m1 <= m0;
            end
            if (v1) begin
                o_delta[m1*DELTA_W +: DELTA_W] <= delta_n;
                m2 <= m1;
            end
            case (state)
                IDLE: if (i_valid) begin
                    px      <= i_p_x;
                    py      <= i_p_y;
                    iss     <= '0;
                    state   <= COMPUTE;
                    o_ready <= 1'b0;
                end
                COMPUTE: if (v2 && int'(m2) == N_MIC-1) begin
                    state   <= DONE;
                    o_valid <= 1'b1;
                end
                DONE: if (i_ready) begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_param_delta_sequencer.sv
// tb_param_delta_sequencer: directed bench with a scoreboard queue of expected delta vectors.
module tb_param_delta_sequencer;
    logic               clk = 0, rst_n = 0;
    logic               i_valid = 0, i_ready = 0, i_thr_we = 0;
    logic               o_ready, o_valid;
    logic signed [9:0]  i_p_x = 0, i_p_y = 0;
    logic [127:0]       o_delta;
    logic [4:0]         i_thr_addr = 0;
    logic [22:0]        i_thr_data = 0;

    int                 checks = 0, errors = 0, lat;
    int                 tb_thr [32];
    int                 offs [4] = '{120, 40, -40, -120};
    logic [127:0]       q [$];
    logic [127:0]       held, all147;

    param_delta_sequencer dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_p_x(i_p_x), .i_p_y(i_p_y), .o_valid(o_valid), .i_ready(i_ready),
        .o_delta(o_delta), .i_thr_we(i_thr_we), .i_thr_addr(i_thr_addr),
        .i_thr_data(i_thr_data)
    );

    always #5 clk = ~clk;

    function automatic int thr_def(input int k);
        if (k == 0) return 3844;
        if (k == 1) return 12544;
        if (k == 2) return 16900;
        if (k == 3) return 29584;
        if (k == 4) return 36100;
        if (k <= 28) return (190 + 13*(k-4)) * (190 + 13*(k-4));
        if (k == 29) return 280900;
        if (k == 30) return 291600;
        return 302500;
    endfunction

    function automatic logic [127:0] model(input int x, input int y);
        logic [127:0] v = '0;
        for (int m = 0; m < 16; m++) begin
            int rx = x + offs[m % 4];
            int ry = y + offs[m / 4];
            int r2 = rx*rx + ry*ry;
            int n = 0;
            for (int k = 0; k < 32; k++) if (r2 > tb_thr[k]) n++;
            v[m*8 +: 8] = 8'(147 + n);
        end
        return v;
    endfunction

    function automatic logic [7:0] mic(input int m);
        return o_delta[m*8 +: 8];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input int d);
        i_thr_we = 1; i_thr_addr = 5'(a); i_thr_data = 23'(d);
        @(posedge clk); #1;
        i_thr_we = 0;
    endtask

    task automatic send(input int x, input int y);
        int n = 0;
        while (!o_ready && n < 100) begin @(posedge clk); #1; n++; end
        i_p_x = 10'(x); i_p_y = 10'(y); i_valid = 1;
        @(posedge clk); #1;
        i_valid = 0;
        q.push_back(model(x, y));
    endtask

    task automatic wait_out(output int l);
        l = 0;
        while (!o_valid && l < 100) begin @(posedge clk); #1; l++; end
        chk("out_valid_timeout", o_valid, 1);
    endtask

    task automatic take(input string tag);
        logic [127:0] e = q.pop_front();
        chk(tag, o_delta, e);
        i_ready = 1;
        @(posedge clk); #1;
        i_ready = 0;
        chk("back_idle_ready", o_ready, 1);
        chk("back_idle_valid", o_valid, 0);
    endtask

    initial begin
        for (int m = 0; m < 16; m++) all147[m*8 +: 8] = 8'd147;
        for (int k = 0; k < 32; k++) tb_thr[k] = 8388607;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_delta", o_delta, 0);

        send(0, 0);
        wait_out(lat);
        chk("unprog_all147", o_delta, all147);
        take("unprog_vec");

        for (int k = 0; k < 32; k++) begin
            wr(k, thr_def(k));
            tb_thr[k] = thr_def(k);
        end
        send(0, 0);
        wait_out(lat);
        chk("latency", lat, 19);
        chk("p00_mic0", mic(0), 150);
        chk("p00_mic1", mic(1), 149);
        chk("p00_mic5", mic(5), 147);
        chk("p00_mic15", mic(15), 150);
        take("p00_vec");

        send(300, 200);
        wait_out(lat);
        chk("p300_mic0", mic(0), 176);
        chk("p300_mic15", mic(15), 152);
        take("p300_vec");

        send(511, 511);
        wait_out(lat);
        chk("p511_mic0_sat", mic(0), 179);
        take("p511_vec");

        send(-512, 137);
        wait_out(lat);
        take("neg_vec");

        send(-45, -300);
        wait_out(lat);
        held = o_delta;
        i_valid = 1; i_p_x = 10'sd5; i_p_y = 10'sd5;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", o_valid, 1);
            chk("bp_stable", o_delta, held);
            chk("bp_ready", o_ready, 0);
        end
        i_valid = 0;
        take("bp_vec");

        send(0, 0);
        repeat (3) @(posedge clk);
        #1 wr(0, 0);
        wait_out(lat);
        chk("busy_wr_mic5", mic(5), 147);
        take("busy_wr_vec");

        wr(0, 0);
        tb_thr[0] = 0;
        send(0, 0);
        wait_out(lat);
        chk("idle_wr_mic5", mic(5), 148);
        take("idle_wr_vec");

        tb_thr[1] = 0;
        i_thr_we = 1; i_thr_addr = 5'd1; i_thr_data = '0;
        send(0, 0);
        i_thr_we = 0;
        wait_out(lat);
        chk("same_edge_mic5", mic(5), 149);
        take("same_edge_vec");

        send(0, 0);
        void'(q.pop_back());
        repeat (8) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("midrst_valid", o_valid, 0);
        chk("midrst_delta", o_delta, 0);
        chk("midrst_ready", o_ready, 1);
        for (int k = 0; k < 32; k++) tb_thr[k] = 8388607;
        @(posedge clk);
        #1 rst_n = 1;
        send(0, 0);
        wait_out(lat);
        chk("postrst_all147", o_delta, all147);
        take("postrst_vec");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
